// File: rtl/ex_stage_unit.sv
// Execute stage: ALU, branch/jump resolution with predictor update,
// radix-2 shift-add multiplier, and the execute-to-memory pipeline register.
module ex_stage_unit #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned PC_BITS = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [XLEN-1:0]    EX_a,
    input  logic [XLEN-1:0]    EX_b,
    input  logic [XLEN-1:0]    EX_a2,
    input  logic [XLEN-1:0]    EX_b2,
    input  logic [3:0]         EX_alu_op,
    input  logic [4:0]         EX_rd,
    input  logic               EX_ld,
    input  logic               EX_str,
    input  logic               EX_byt,
    input  logic               EX_we,
    input  logic               EX_brn,
    input  logic               EX_jmp,
    input  logic               EX_mul,
    input  logic               EX_BP_taken,
    input  logic [PC_BITS-1:0] EX_BP_target_pc,
    input  logic               EX_link_we,
    input  logic [XLEN-1:0]    EX_link_addr,
    input  logic               MEM_stall,
    output logic               EX_taken,
    output logic [PC_BITS-1:0] EX_redirect_pc,
    output logic               ex_stall,
    output logic               bp_upd_valid,
    output logic               bp_upd_taken,
    output logic [PC_BITS-1:0] bp_upd_pc,
    output logic [PC_BITS-1:0] bp_upd_target,
    output logic [XLEN-1:0]    M_result,
    output logic [XLEN-1:0]    M_b2,
    output logic [4:0]         M_rd,
    output logic               M_ld,
    output logic               M_str,
    output logic               M_byt,
    output logic               M_we
);
    localparam int unsigned CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} mul_state_e;

    mul_state_e        state_q, state_d;
    logic [XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [XLEN-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [4:0]        shamt;
    logic [XLEN-1:0]   alu_res;
    logic [XLEN-1:0]   ex_result;
    logic              cond_true;
    logic              actual_taken;
    logic              mispredict;
    logic              is_cf;
    logic [PC_BITS-1:0] br_tgt, jmp_tgt, fall_pc, res_tgt;

    assign shamt = EX_b[4:0];

    always_comb begin
        alu_res = '0;
        case (EX_alu_op)
            4'd0:    alu_res = EX_a + EX_b;
            4'd1:    alu_res = EX_a - EX_b;
            4'd2:    alu_res = EX_a & EX_b;
            4'd3:    alu_res = EX_a | EX_b;
            4'd4:    alu_res = EX_a ^ EX_b;
            4'd5:    alu_res = EX_a << shamt;
            4'd6:    alu_res = EX_a >> shamt;
            4'd7:    alu_res = XLEN'($signed(EX_a) >>> shamt);
            4'd8:    alu_res = XLEN'($signed(EX_a) < $signed(EX_b));
            4'd9:    alu_res = XLEN'(EX_a < EX_b);
            default: alu_res = '0;
        endcase
    end

    // Branch condition shares the opcode field when EX_brn is set
    always_comb begin
        cond_true = 1'b0;
        case (EX_alu_op)
            4'd0:    cond_true = (EX_a == EX_b);
            4'd1:    cond_true = (EX_a != EX_b);
            4'd2:    cond_true = ($signed(EX_a) <  $signed(EX_b));
            4'd3:    cond_true = ($signed(EX_a) >= $signed(EX_b));
            4'd4:    cond_true = (EX_a <  EX_b);
            4'd5:    cond_true = (EX_a >= EX_b);
            default: cond_true = 1'b0;
        endcase
    end

    assign br_tgt       = PC_BITS'(EX_a2 + EX_b2);
    assign jmp_tgt      = PC_BITS'(EX_a + EX_b);
    assign fall_pc      = PC_BITS'(EX_a2 + XLEN'(4));
    assign is_cf        = EX_brn | EX_jmp;
    assign actual_taken = EX_jmp | (EX_brn & cond_true);
    assign res_tgt      = EX_jmp ? jmp_tgt : br_tgt;
    assign mispredict   = (actual_taken != EX_BP_taken) |
                          (actual_taken & (res_tgt != EX_BP_target_pc));

    // Reset also releases the front end immediately, even mid-multiply
    assign ex_stall       = EX_mul & (state_q != S_DONE) & ~rst;
    assign EX_taken       = is_cf & mispredict & ~MEM_stall & ~ex_stall;
    assign bp_upd_valid   = is_cf & ~MEM_stall & ~ex_stall;
    assign bp_upd_taken   = actual_taken;
    assign bp_upd_pc      = PC_BITS'(EX_a2);
    assign bp_upd_target  = res_tgt;
    assign EX_redirect_pc = actual_taken ? res_tgt : fall_pc;

    assign ex_result = EX_link_we ? EX_link_addr :
                       EX_mul     ? acc_q        : alu_res;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (EX_mul) begin
                    mcand_d  = EX_a;
                    mplier_d = EX_b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_BUSY;
                end
            end
            S_BUSY: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (!MEM_stall) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    // Memory stall holds M; a busy multiplier sends a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            M_result <= '0;
            M_b2     <= '0;
            M_rd     <= '0;
            M_ld     <= 1'b0;
            M_str    <= 1'b0;
            M_byt    <= 1'b0;
            M_we     <= 1'b0;
        end else if (!MEM_stall) begin
            if (ex_stall) begin
                M_result <= '0;
                M_b2     <= '0;
                M_rd     <= '0;
                M_ld     <= 1'b0;
                M_str    <= 1'b0;
                M_byt    <= 1'b0;
                M_we     <= 1'b0;
            end else begin
                M_result <= ex_result;
                M_b2     <= EX_b2;
                M_rd     <= EX_rd;
                M_ld     <= EX_ld;
                M_str    <= EX_str;
                M_byt    <= EX_byt;
                M_we     <= EX_we | EX_link_we;
            end
        end
    end
endmodule

// File: tb/tb_ex_stage_unit.sv
// Bench for ex_stage_unit: arithmetic reference model checked every negedge,
// plus directed vectors with hand-computed literal expectations.
module tb_ex_stage_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] EX_a, EX_b, EX_a2, EX_b2, EX_link_addr;
    logic [3:0]  EX_alu_op;
    logic [4:0]  EX_rd;
    logic        EX_ld, EX_str, EX_byt, EX_we, EX_brn, EX_jmp, EX_mul;
    logic        EX_BP_taken, EX_link_we, MEM_stall;
    logic [11:0] EX_BP_target_pc;
    logic        EX_taken, ex_stall, bp_upd_valid, bp_upd_taken;
    logic [11:0] EX_redirect_pc, bp_upd_pc, bp_upd_target;
    logic [31:0] M_result, M_b2;
    logic [4:0]  M_rd;
    logic        M_ld, M_str, M_byt, M_we;

    int checks = 0;
    int errors = 0;

    ex_stage_unit #(.XLEN(32), .PC_BITS(12)) dut (
        .clk(clk), .rst(rst),
        .EX_a(EX_a), .EX_b(EX_b), .EX_a2(EX_a2), .EX_b2(EX_b2),
        .EX_alu_op(EX_alu_op), .EX_rd(EX_rd),
        .EX_ld(EX_ld), .EX_str(EX_str), .EX_byt(EX_byt), .EX_we(EX_we),
        .EX_brn(EX_brn), .EX_jmp(EX_jmp), .EX_mul(EX_mul),
        .EX_BP_taken(EX_BP_taken), .EX_BP_target_pc(EX_BP_target_pc),
        .EX_link_we(EX_link_we), .EX_link_addr(EX_link_addr),
        .MEM_stall(MEM_stall),
        .EX_taken(EX_taken), .EX_redirect_pc(EX_redirect_pc), .ex_stall(ex_stall),
        .bp_upd_valid(bp_upd_valid), .bp_upd_taken(bp_upd_taken),
        .bp_upd_pc(bp_upd_pc), .bp_upd_target(bp_upd_target),
        .M_result(M_result), .M_b2(M_b2), .M_rd(M_rd),
        .M_ld(M_ld), .M_str(M_str), .M_byt(M_byt), .M_we(M_we)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int          sa, sb;
        logic [31:0] ones;
        int unsigned s;
        sa = a; sb = b; ones = 32'hFFFF_FFFF; s = int'(b & 32'd31);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a << s;
            4'd6: return a >> s;
            4'd7: return (a >> s) | ((sa < 0) ? ~(ones >> s) : 32'd0);
            4'd8: return (sa < sb) ? 32'd1 : 32'd0;
            4'd9: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic cond_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a; sb = b;
        case (op)
            4'd0: return a == b;
            4'd1: return a != b;
            4'd2: return sa < sb;
            4'd3: return sa >= sb;
            4'd4: return a < b;
            4'd5: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // Reference model: multiply occupancy as cycles spent in EX, M as the last accepted result
    int          age;
    logic        md_stall;
    logic [31:0] em_result, em_b2;
    logic [4:0]  em_rd;
    logic        em_ld, em_str, em_byt, em_we;
    logic [31:0] s_jt, s_bt, s_ft;
    logic        e_act, e_mis, e_cf, e_gate;
    logic [11:0] e_tgt, e_redir;

    assign md_stall = EX_mul && (age < 33) && !rst;

    always_comb begin
        s_jt    = EX_a + EX_b;
        s_bt    = EX_a2 + EX_b2;
        s_ft    = EX_a2 + 32'd4;
        e_act   = EX_jmp | (EX_brn & cond_ref(EX_alu_op, EX_a, EX_b));
        e_tgt   = EX_jmp ? s_jt[11:0] : s_bt[11:0];
        e_redir = e_act ? e_tgt : s_ft[11:0];
        e_mis   = (e_act != EX_BP_taken) || (e_act && (e_tgt != EX_BP_target_pc));
        e_cf    = EX_brn | EX_jmp;
        e_gate  = e_cf && !MEM_stall && !md_stall;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            age <= 0;
            em_result <= '0; em_b2 <= '0; em_rd <= '0;
            em_ld <= 1'b0; em_str <= 1'b0; em_byt <= 1'b0; em_we <= 1'b0;
        end else begin
            if (!MEM_stall) begin
                if (md_stall) begin
                    em_result <= '0; em_b2 <= '0; em_rd <= '0;
                    em_ld <= 1'b0; em_str <= 1'b0; em_byt <= 1'b0; em_we <= 1'b0;
                end else begin
                    em_result <= EX_link_we ? EX_link_addr :
                                 EX_mul ? EX_a * EX_b : alu_ref(EX_alu_op, EX_a, EX_b);
                    em_b2  <= EX_b2;
                    em_rd  <= EX_rd;
                    em_ld  <= EX_ld;
                    em_str <= EX_str;
                    em_byt <= EX_byt;
                    em_we  <= EX_we | EX_link_we;
                end
            end
            if (EX_mul) begin
                if (md_stall) age <= age + 1;
                else if (!MEM_stall) age <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("m_ex_stall", 32'(ex_stall), 32'(md_stall));
            chk("m_EX_taken", 32'(EX_taken), 32'(e_gate && e_mis));
            chk("m_bp_upd_valid", 32'(bp_upd_valid), 32'(e_gate));
            if (e_cf) begin
                chk("m_redirect", 32'(EX_redirect_pc), 32'(e_redir));
                chk("m_bp_upd_taken", 32'(bp_upd_taken), 32'(e_act));
                chk("m_bp_upd_target", 32'(bp_upd_target), 32'(e_tgt));
                chk("m_bp_upd_pc", 32'(bp_upd_pc), 32'(EX_a2[11:0]));
            end
            chk("m_M_result", M_result, em_result);
            chk("m_M_b2", M_b2, em_b2);
            chk("m_M_rd", 32'(M_rd), 32'(em_rd));
            chk("m_M_ctl", {28'd0, M_ld, M_str, M_byt, M_we}, {28'd0, em_ld, em_str, em_byt, em_we});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nop();
        EX_a = '0; EX_b = '0; EX_a2 = '0; EX_b2 = '0; EX_alu_op = '0; EX_rd = '0;
        EX_ld = 1'b0; EX_str = 1'b0; EX_byt = 1'b0; EX_we = 1'b0;
        EX_brn = 1'b0; EX_jmp = 1'b0; EX_mul = 1'b0;
        EX_BP_taken = 1'b0; EX_BP_target_pc = '0;
        EX_link_we = 1'b0; EX_link_addr = '0;
    endtask

    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        set_nop();
        EX_mul = 1'b1; EX_a = a; EX_b = b; EX_we = 1'b1; EX_rd = 5'd9;
        for (int c = 1; c <= 34; c++) begin
            #1 chk("mul_stall", 32'(ex_stall), (c <= 33) ? 32'd1 : 32'd0);
            tick();
            if (c < 34) begin
                chk("mul_bubble_we", 32'(M_we), 32'd0);
            end else begin
                chk("mul_result", M_result, exp);
                chk("mul_we", 32'(M_we), 32'd1);
            end
        end
        set_nop();
    endtask

    logic [3:0]  sw_op  [5] = '{4'd1, 4'd7, 4'd6, 4'd8, 4'd9};
    logic [31:0] sw_exp [5] = '{32'hFFFF_FFEC, 32'hFFFF_FFFF, 32'h0FFF_FFFF, 32'd1, 32'd0};

    initial begin
        rst = 1'b1; MEM_stall = 1'b0;
        set_nop();
        #3;
        chk("rst_M_result", M_result, 32'd0);
        chk("rst_M_we", 32'(M_we), 32'd0);
        chk("rst_ex_stall", 32'(ex_stall), 32'd0);
        chk("rst_EX_taken", 32'(EX_taken), 32'd0);
        chk("rst_bp_upd_valid", 32'(bp_upd_valid), 32'd0);
        #9 rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            set_nop();
            EX_a = 32'hFFFF_FFF0; EX_b = 32'd4; EX_we = 1'b1; EX_rd = 5'(i + 1);
            EX_alu_op = sw_op[i];
            tick();
            chk("alu_result", M_result, sw_exp[i]);
            chk("alu_we", 32'(M_we), 32'd1);
        end
        for (int op = 0; op < 16; op++) begin
            set_nop();
            EX_a = 32'h8000_0F0F; EX_b = 32'h0000_0023; EX_b2 = 32'h55AA_0000 + 32'(op);
            EX_alu_op = 4'(op); EX_we = 1'(op & 1); EX_rd = 5'(op);
            EX_ld = 1'(op == 3); EX_str = 1'(op == 4); EX_byt = 1'(op == 5);
            tick();
        end

        set_nop();
        EX_brn = 1'b1; EX_alu_op = 4'd0; EX_a = 32'd5; EX_b = 32'd5;
        EX_a2 = 32'h100; EX_b2 = 32'h20;
        #1;
        chk("beq_taken", 32'(EX_taken), 32'd1);
        chk("beq_redirect", 32'(EX_redirect_pc), 32'h120);
        chk("beq_upd_valid", 32'(bp_upd_valid), 32'd1);
        chk("beq_upd_taken", 32'(bp_upd_taken), 32'd1);
        tick();
        EX_BP_taken = 1'b1; EX_BP_target_pc = 12'h120;
        #1;
        chk("beq_pred_taken", 32'(EX_taken), 32'd0);
        chk("beq_pred_valid", 32'(bp_upd_valid), 32'd1);
        tick();
        EX_alu_op = 4'd2; EX_a = 32'd5; EX_b = 32'd3;
        #1;
        chk("blt_nt_taken", 32'(EX_taken), 32'd1);
        chk("blt_nt_redirect", 32'(EX_redirect_pc), 32'h104);
        tick();

        run_mul(32'd7, 32'd6, 32'd42);
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);

        set_nop();
        EX_a = 32'd1; EX_b = 32'd2; EX_we = 1'b1; EX_rd = 5'd4;
        tick();
        chk("pre_add", M_result, 32'd3);
        set_nop();
        EX_brn = 1'b1; EX_alu_op = 4'd1; EX_a = 32'd1; EX_b = 32'd2;
        EX_a2 = 32'h200; EX_b2 = 32'h40; EX_rd = 5'd7; MEM_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_taken", 32'(EX_taken), 32'd0);
            chk("stall_valid", 32'(bp_upd_valid), 32'd0);
            tick();
            chk("stall_hold_result", M_result, 32'd3);
            chk("stall_hold_we", 32'(M_we), 32'd1);
        end
        MEM_stall = 1'b0;
        #1;
        chk("bne_taken", 32'(EX_taken), 32'd1);
        chk("bne_redirect", 32'(EX_redirect_pc), 32'h240);
        tick();
        chk("bne_M_result", M_result, 32'hFFFF_FFFF);
        chk("bne_M_rd", 32'(M_rd), 32'd7);
        chk("bne_M_b2", M_b2, 32'h40);
        chk("bne_M_we", 32'(M_we), 32'd0);
        set_nop();
        #1 chk("bne_once", 32'(EX_taken), 32'd0);
        tick();

        EX_jmp = 1'b1; EX_link_we = 1'b1; EX_link_addr = 32'h204;
        EX_a = 32'h100; EX_b = 32'h200; EX_a2 = 32'h80; EX_rd = 5'd1;
        EX_BP_taken = 1'b1; EX_BP_target_pc = 12'h300;
        #1;
        chk("jalx_taken", 32'(EX_taken), 32'd0);
        chk("jalx_valid", 32'(bp_upd_valid), 32'd1);
        chk("jalx_redirect", 32'(EX_redirect_pc), 32'h300);
        tick();
        chk("jalx_M_result", M_result, 32'h204);
        chk("jalx_M_we", 32'(M_we), 32'd1);
        EX_BP_target_pc = 12'h2FC;
        #1 chk("jmp_badtgt_taken", 32'(EX_taken), 32'd1);
        tick();

        set_nop();
        EX_a = 32'h11; EX_b = 32'h22; EX_we = 1'b1;
        tick();
        chk("pre_rst_add", M_result, 32'h33);
        set_nop();
        EX_mul = 1'b1; EX_a = 32'd7; EX_b = 32'd7; EX_we = 1'b1; MEM_stall = 1'b1;
        repeat (11) tick();
        chk("busy_stall", 32'(ex_stall), 32'd1);
        chk("busy_hold", M_result, 32'h33);
        #1 rst = 1'b1;
        #1;
        chk("arst_M_result", M_result, 32'd0);
        chk("arst_M_we", 32'(M_we), 32'd0);
        chk("arst_ex_stall", 32'(ex_stall), 32'd0);
        set_nop();
        MEM_stall = 1'b0;
        tick();
        #3 rst = 1'b0;
        tick();
        run_mul(32'd3, 32'd3, 32'd9);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
